// File: rtl/btb_predictor.sv
// Branch target buffer with a 2-bit bimodal direction counter per entry.
// The fetch-side lookup is purely combinational. Resolved branches arriving
// from MEM train the table on the next rising edge. Two saturating counters
// record predicted-taken lookups and reported mispredicts.
module btb_predictor #(
    parameter int ENTRIES  = 16,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_addr,
    output logic        IF_prediction,
    output logic [31:0] BTB_target,
    input  logic        MEM_br_valid,
    input  logic [31:0] MEM_pc,
    input  logic        MEM_taken,
    input  logic [31:0] MEM_target,
    input  logic        MEM_mispredict,
    output logic [31:0] perf_pred_taken,
    output logic [31:0] perf_mispredict
);

    localparam int TAG_BITS = 32 - IDX_BITS - 2;

    // Direction counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];

    logic [31:0]         r_perf_pred;
    logic [31:0]         r_perf_mis;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic                w_if_hit;
    logic                w_if_pred;
    logic [31:0]         w_if_target;

    logic [IDX_BITS-1:0] w_mem_idx;
    logic [TAG_BITS-1:0] w_mem_tag;
    logic                w_mem_hit;
    logic [31:0]         w_mem_target;

    assign w_if_idx     = IF_addr[IDX_BITS+1:2];
    assign w_if_tag     = IF_addr[31:IDX_BITS+2];
    assign w_mem_idx    = MEM_pc[IDX_BITS+1:2];
    assign w_mem_tag    = MEM_pc[31:IDX_BITS+2];
    assign w_mem_target = {MEM_target[31:1], 1'b0};

    // Fetch lookup: reads only registered state, so a same-cycle update to the
    // same index is not visible until the following cycle.
    always_comb begin
        w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
        w_if_pred   = w_if_hit && r_ctr[w_if_idx][1];
        w_if_target = w_if_hit ? r_target[w_if_idx] : 32'h0;
    end

    // Hit test for the resolving branch against the entry it maps to.
    always_comb begin
        w_mem_hit = r_valid[w_mem_idx] && (r_tag[w_mem_idx] == w_mem_tag);
    end

    assign IF_prediction   = w_if_pred;
    assign BTB_target      = w_if_target;
    assign perf_pred_taken = r_perf_pred;
    assign perf_mispredict = r_perf_mis;

    // Table training: hits move the counter, taken misses allocate at weak-T,
    // not-taken misses leave the table alone. Reset overrides any update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_ctr[i]    <= CTR_RESET;
            end
        end else if (MEM_br_valid) begin
            if (w_mem_hit) begin
                if (MEM_taken) begin
                    if (r_ctr[w_mem_idx] != CTR_MAX) begin
                        r_ctr[w_mem_idx] <= r_ctr[w_mem_idx] + 2'd1;
                    end
                    r_target[w_mem_idx] <= w_mem_target;
                end else if (r_ctr[w_mem_idx] != CTR_MIN) begin
                    r_ctr[w_mem_idx] <= r_ctr[w_mem_idx] - 2'd1;
                end
            end else if (MEM_taken) begin
                r_valid[w_mem_idx]  <= 1'b1;
                r_tag[w_mem_idx]    <= w_mem_tag;
                r_target[w_mem_idx] <= w_mem_target;
                r_ctr[w_mem_idx]    <= CTR_ALLOC;
            end
        end
    end

    // Performance counters, saturating at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_pred <= 32'h0;
            r_perf_mis  <= 32'h0;
        end else begin
            if (w_if_pred && (r_perf_pred != 32'hFFFF_FFFF)) begin
                r_perf_pred <= r_perf_pred + 32'd1;
            end
            if (MEM_br_valid && MEM_mispredict && (r_perf_mis != 32'hFFFF_FFFF)) begin
                r_perf_mis <= r_perf_mis + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed scenarios plus a randomized run against a
// behavioural table model built from the prediction/training rules.
module tb_btb_predictor;

    localparam int ENTRIES = 16;

    logic        clk;
    logic        rst;
    logic [31:0] IF_addr;
    logic        IF_prediction;
    logic [31:0] BTB_target;
    logic        MEM_br_valid;
    logic [31:0] MEM_pc;
    logic        MEM_taken;
    logic [31:0] MEM_target;
    logic        MEM_mispredict;
    logic [31:0] perf_pred_taken;
    logic [31:0] perf_mispredict;

    int total = 0;
    int bad   = 0;

    // Behavioural model: per-slot valid / line number / target / counter value.
    bit          m_valid  [ENTRIES];
    int unsigned m_line   [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    longint      m_pred_cnt;
    longint      m_mis_cnt;

    btb_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk            (clk),
        .rst            (rst),
        .IF_addr        (IF_addr),
        .IF_prediction  (IF_prediction),
        .BTB_target     (BTB_target),
        .MEM_br_valid   (MEM_br_valid),
        .MEM_pc         (MEM_pc),
        .MEM_taken      (MEM_taken),
        .MEM_target     (MEM_target),
        .MEM_mispredict (MEM_mispredict),
        .perf_pred_taken(perf_pred_taken),
        .perf_mispredict(perf_mispredict)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slot_of(input logic [31:0] a);
        return int'((a >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned line_of(input logic [31:0] a);
        return int'(a / (4 * ENTRIES));
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot_of(a)] && (m_line[slot_of(a)] == line_of(a));
    endfunction

    function automatic bit m_pred(input logic [31:0] a);
        return m_hit(a) && (m_ctr[slot_of(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_tgt(input logic [31:0] a);
        return m_hit(a) ? m_target[slot_of(a)] : 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_line[i]   = 0;
            m_target[i] = 32'h0;
            m_ctr[i]    = 1;
        end
        m_pred_cnt = 0;
        m_mis_cnt  = 0;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        int s;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (m_pred(IF_addr) && m_pred_cnt < 64'hFFFF_FFFF) m_pred_cnt++;
            if (MEM_br_valid && MEM_mispredict && m_mis_cnt < 64'hFFFF_FFFF) m_mis_cnt++;
            if (MEM_br_valid) begin
                s = slot_of(MEM_pc);
                if (m_hit(MEM_pc)) begin
                    if (MEM_taken) begin
                        m_ctr[s]    = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                        m_target[s] = MEM_target & 32'hFFFF_FFFE;
                    end else begin
                        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                    end
                end else if (MEM_taken) begin
                    m_valid[s]  = 1'b1;
                    m_line[s]   = line_of(MEM_pc);
                    m_target[s] = MEM_target & 32'hFFFF_FFFE;
                    m_ctr[s]    = 2;
                end
            end
        end
        #1;
    endtask

    task automatic drive_idle();
        MEM_br_valid   = 1'b0;
        MEM_pc         = 32'h0;
        MEM_taken      = 1'b0;
        MEM_target     = 32'h0;
        MEM_mispredict = 1'b0;
    endtask

    task automatic update_once(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        MEM_br_valid = 1'b1;
        MEM_pc       = pc;
        MEM_taken    = tk;
        MEM_target   = tg;
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        IF_addr = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        IF_addr = 32'h0000_0040;
        #1;
        total++;
        if (IF_prediction !== 1'b0) begin
            bad++; $display("FAIL reset_pred got=%0b want=0", IF_prediction);
        end
        total++;
        if (BTB_target !== 32'h0) begin
            bad++; $display("FAIL reset_target got=%h want=0", BTB_target);
        end
        total++;
        if (perf_pred_taken !== 32'h0) begin
            bad++; $display("FAIL reset_perf_pred got=%0d want=0", perf_pred_taken);
        end
        total++;
        if (perf_mispredict !== 32'h0) begin
            bad++; $display("FAIL reset_perf_mis got=%0d want=0", perf_mispredict);
        end
    endtask

    task automatic test_alloc();
        IF_addr = 32'h0;
        update_once(32'h40, 1'b1, 32'h0000_0101);
        IF_addr = 32'h40;
        #1;
        total++;
        if (IF_prediction !== 1'b1) begin
            bad++; $display("FAIL alloc_pred got=%0b want=1", IF_prediction);
        end
        total++;
        if (BTB_target !== 32'h0000_0100) begin
            bad++; $display("FAIL alloc_target got=%h want=00000100", BTB_target);
        end
        IF_addr = 32'h440;
        #1;
        total++;
        if (IF_prediction !== 1'b0) begin
            bad++; $display("FAIL alloc_alias_pred got=%0b want=0", IF_prediction);
        end
    endtask

    task automatic test_counter();
        logic exp_seq [9];
        logic tk_seq  [9];
        // NT,NT,NT (saturate low), T,T,T,T (saturate high), NT, T
        tk_seq  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        IF_addr = 32'h0;
        for (int i = 0; i < 9; i++) begin
            update_once(32'h40, tk_seq[i], 32'h0000_0101);
            IF_addr = 32'h40;
            #1;
            total++;
            if (IF_prediction !== exp_seq[i]) begin
                bad++; $display("FAIL ctr_step%0d_pred got=%0b want=%0b", i, IF_prediction, exp_seq[i]);
            end
            total++;
            if (BTB_target !== 32'h0000_0100) begin
                bad++; $display("FAIL ctr_step%0d_hit_target got=%h want=00000100", i, BTB_target);
            end
            IF_addr = 32'h0;
        end
    endtask

    task automatic test_same_cycle();
        IF_addr      = 32'h80;
        MEM_br_valid = 1'b1;
        MEM_pc       = 32'h80;
        MEM_taken    = 1'b1;
        MEM_target   = 32'h0000_3001;
        #1;
        total++;
        if (IF_prediction !== 1'b0) begin
            bad++; $display("FAIL same_cycle_pred got=%0b want=0", IF_prediction);
        end
        tick();
        drive_idle();
        #1;
        total++;
        if (IF_prediction !== 1'b1) begin
            bad++; $display("FAIL same_cycle_next_pred got=%0b want=1", IF_prediction);
        end
        total++;
        if (BTB_target !== 32'h0000_3000) begin
            bad++; $display("FAIL same_cycle_next_target got=%h want=00003000", BTB_target);
        end
    endtask

    task automatic test_evict();
        IF_addr = 32'h0;
        update_once(32'h440, 1'b1, 32'h0000_2000);
        IF_addr = 32'h40;
        #1;
        total++;
        if (IF_prediction !== 1'b0 || BTB_target !== 32'h0) begin
            bad++; $display("FAIL evict_old got=%0b/%h want=0/00000000", IF_prediction, BTB_target);
        end
        IF_addr = 32'h440;
        #1;
        total++;
        if (IF_prediction !== 1'b1 || BTB_target !== 32'h0000_2000) begin
            bad++; $display("FAIL evict_new got=%0b/%h want=1/00002000", IF_prediction, BTB_target);
        end
        update_once(32'h8, 1'b0, 32'h0000_5000);
        IF_addr = 32'h8;
        #1;
        total++;
        if (IF_prediction !== 1'b0 || BTB_target !== 32'h0) begin
            bad++; $display("FAIL nt_miss_noalloc got=%0b/%h want=0/00000000", IF_prediction, BTB_target);
        end
    endtask

    task automatic test_perf();
        logic [31:0] base_mis;
        base_mis = perf_mispredict;
        IF_addr  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            MEM_br_valid   = (i != 2);
            MEM_pc         = 32'h8;
            MEM_taken      = 1'b0;
            MEM_mispredict = 1'b1;
            tick();
        end
        drive_idle();
        #1;
        total++;
        if (perf_mispredict - base_mis !== 32'd3) begin
            bad++; $display("FAIL perf_mis_delta got=%0d want=3", perf_mispredict - base_mis);
        end
        total++;
        if (perf_mispredict !== m_mis_cnt[31:0]) begin
            bad++; $display("FAIL perf_mis got=%0d want=%0d", perf_mispredict, m_mis_cnt);
        end
        total++;
        if (perf_pred_taken !== m_pred_cnt[31:0]) begin
            bad++; $display("FAIL perf_pred got=%0d want=%0d", perf_pred_taken, m_pred_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        for (int i = 0; i < 8; i++) begin
            pool[i] = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
        end
        for (int c = 0; c < 400; c++) begin
            IF_addr        = pool[$urandom_range(0, 7)] | $urandom_range(0, 3);
            MEM_br_valid   = $urandom_range(0, 1);
            MEM_pc         = pool[$urandom_range(0, 7)] | $urandom_range(0, 3);
            MEM_taken      = ($urandom_range(0, 3) != 0);
            MEM_target     = $urandom;
            MEM_mispredict = $urandom_range(0, 1);
            #1;
            total++;
            if (IF_prediction !== m_pred(IF_addr)) begin
                bad++; $display("FAIL rand_pred c=%0d addr=%h got=%0b want=%0b", c, IF_addr, IF_prediction, m_pred(IF_addr));
            end
            total++;
            if (BTB_target !== m_tgt(IF_addr)) begin
                bad++; $display("FAIL rand_target c=%0d addr=%h got=%h want=%h", c, IF_addr, BTB_target, m_tgt(IF_addr));
            end
            tick();
        end
        drive_idle();
        #1;
        total++;
        if (perf_pred_taken !== m_pred_cnt[31:0]) begin
            bad++; $display("FAIL rand_perf_pred got=%0d want=%0d", perf_pred_taken, m_pred_cnt);
        end
        total++;
        if (perf_mispredict !== m_mis_cnt[31:0]) begin
            bad++; $display("FAIL rand_perf_mis got=%0d want=%0d", perf_mispredict, m_mis_cnt);
        end
    endtask

    task automatic test_reset_with_update();
        IF_addr = 32'h0;
        update_once(32'h440, 1'b1, 32'h0000_2000);
        rst          = 1'b1;
        MEM_br_valid = 1'b1;
        MEM_pc       = 32'h40;
        MEM_taken    = 1'b1;
        MEM_target   = 32'h0000_0700;
        MEM_mispredict = 1'b1;
        tick();
        rst = 1'b0;
        drive_idle();
        IF_addr = 32'h40;
        #1;
        total++;
        if (IF_prediction !== 1'b0 || BTB_target !== 32'h0) begin
            bad++; $display("FAIL rst_upd_discard got=%0b/%h want=0/00000000", IF_prediction, BTB_target);
        end
        IF_addr = 32'h440;
        #1;
        total++;
        if (IF_prediction !== 1'b0 || BTB_target !== 32'h0) begin
            bad++; $display("FAIL rst_upd_cleared got=%0b/%h want=0/00000000", IF_prediction, BTB_target);
        end
        total++;
        if (perf_pred_taken !== 32'h0 || perf_mispredict !== 32'h0) begin
            bad++; $display("FAIL rst_upd_perf got=%0d/%0d want=0/0", perf_pred_taken, perf_mispredict);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_alloc();
        test_counter();
        test_same_cycle();
        test_evict();
        test_perf();
        test_random();
        test_reset_with_update();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
